mult_issue_ctrl: RTL

MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_op_fifo.sv | 59 +++++
 rtl/mult_issue_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue controller: FSM encoding,
// operand/product widths and the value reported when the multiplier times out.
package mult_pkg;

  localparam int OPND_W = 32;
  localparam int PROD_W = 64;

  localparam logic [PROD_W-1:0] TIMEOUT_SENTINEL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand-pair queue: power-of-two depth, wrapping pointers,
// push ignored when full and pop ignored when empty.
module mult_op_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 64
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == LVL_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock_in) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer width equals log2(depth), so increments wrap modulo FIFO_DEPTH.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Queues operand pairs and issues them one at a time to a multi-cycle multiplier,
// holding each product for the consumer. Optional watchdog: MULT_ISSUE_TIMEOUT_EN.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [OPND_W-1:0]             op_a,
  input  logic [OPND_W-1:0]             op_b,
  output logic                          mul_enable,
  output logic [PROD_W-1:0]             mul_operand,
  input  logic                          mul_busy,
  input  logic [PROD_W-1:0]             mul_result,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [PROD_W-1:0]             res_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_err
);

  mult_state_t       state;
  mult_state_t       state_next;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PROD_W-1:0] fifo_head;
  logic              capture_res;
  logic              wait_expired;

  assign op_ready  = !reset && !fifo_full;
  assign fifo_push = op_valid && op_ready;

  mult_op_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (PROD_W)
  ) u_fifo (
    .clock_in (clock_in),
    .reset    (reset),
    .push     (fifo_push),
    .wdata    ({op_a, op_b}),
    .pop      (fifo_pop),
    .rdata    (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef MULT_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // The cycle that would bring the count to TIMEOUT_CYCLES ends the wait.
  assign wait_expired = (state == ST_WAIT) && mul_busy &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err  = timeout_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != ST_WAIT) begin
        wait_cnt <= '0;
      end else if (mul_busy && !wait_expired) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A pop always coincides with entry to ISSUE, from IDLE or straight from HOLD.
  always_comb begin
    state_next  = state;
    fifo_pop    = 1'b0;
    capture_res = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_ISSUE;
          fifo_pop   = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mul_busy) begin
          state_next  = ST_HOLD;
          capture_res = 1'b1;
        end else if (wait_expired) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            state_next = ST_ISSUE;
            fifo_pop   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mul_enable = (state == ST_ISSUE);
  assign res_valid  = (state == ST_HOLD);

  // Operand only changes on a pop, so it holds through ISSUE and WAIT.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      mul_operand <= '0;
    end else if (fifo_pop) begin
      mul_operand <= fifo_head;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      res_data <= '0;
    end else if (capture_res) begin
      res_data <= mul_result;
    end else if (wait_expired) begin
      res_data <= TIMEOUT_SENTINEL;
    end
  end

endmodule
